// File: rtl/arbitro_multiplicador_fp_pkg.sv
// Shared FP definitions for the arbitrated multiplier: field widths, bias, FSM encoding
// and helpers that split a {sign, exp, mant} word into its fields.
package fp_pkg;

  localparam int W      = 16;
  localparam int EXP_W  = 7;
  localparam int MANT_W = 8;
  localparam int BIAS   = 63;
  localparam logic [EXP_W-1:0] EXP_MAX = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESULT
  } state_t;

  function automatic logic get_sign(input logic [W-1:0] x);
    return x[W-1];
  endfunction

  function automatic logic [EXP_W-1:0] get_exp(input logic [W-1:0] x);
    return x[W-2:MANT_W];
  endfunction

  function automatic logic [MANT_W-1:0] get_mant(input logic [W-1:0] x);
    return x[MANT_W-1:0];
  endfunction

endpackage

// File: rtl/multiplicador_mantiza.sv
// 8x8 mantissa multiply with hidden leading one; normalises the [1,4) product
// back to 1.m and reports via inc when a one-bit right shift was needed.
module multiplicador_mantiza
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  output logic [MANT_W-1:0] mant,
  output logic              inc
);

  logic [2*MANT_W+1:0] prod;
  logic [MANT_W+1:0]   prod_hi;

  assign prod    = {1'b1, mant_a} * {1'b1, mant_b};
  // Low product bits are truncated; only the integer bits and top fraction matter
  assign prod_hi = (MANT_W+2)'(prod >> MANT_W);
  assign inc     = prod_hi[MANT_W+1];
  assign mant    = inc ? prod_hi[MANT_W:1] : prod_hi[MANT_W-1:0];

endmodule

// File: rtl/arbitro_multiplicador_fp.sv
// Two-requester arbiter sequencing one shared FP multiplier; result held until consumed.
// Define ARBITRO_FP_RR_EN for round-robin ties, otherwise A has fixed priority.
module arbitro_multiplicador_fp
  import fp_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid_a,
  input  logic         i_valid_b,
  output logic         o_ready_a,
  output logic         o_ready_b,
  input  logic [W-1:0] i_op1_a,
  input  logic [W-1:0] i_op2_a,
  input  logic [W-1:0] i_op1_b,
  input  logic [W-1:0] i_op2_b,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_resultado,
  output logic         o_id,
  output logic         o_overflow,
  output logic         o_underflow
);

  state_t state;

  logic              sign_q;
  logic              zero_q;
  logic              id_q;
  logic [EXP_W-1:0]  e1_q, e2_q;
  logic [MANT_W-1:0] m1_q, m2_q;

  logic              grant_a, grant_b;
  logic [W-1:0]      sel_op1, sel_op2;

  logic [MANT_W-1:0] mant;
  logic              inc;
  logic signed [EXP_W+1:0] exp_sum;

  logic [W-1:0]      res_next;
  logic              ov_next, un_next;

`ifdef ARBITRO_FP_RR_EN
  // 1 = B was granted last; resets to B so A takes the first tie
  logic last_grant;
  assign grant_a = i_valid_a && (!i_valid_b || last_grant);
`else
  assign grant_a = i_valid_a;
`endif
  assign grant_b = i_valid_b && !grant_a;

  assign o_ready_a = !i_rst && (state == IDLE) && grant_a;
  assign o_ready_b = !i_rst && (state == IDLE) && grant_b;

  assign sel_op1 = grant_b ? i_op1_b : i_op1_a;
  assign sel_op2 = grant_b ? i_op2_b : i_op2_a;

  multiplicador_mantiza u_mant (
    .mant_a (m1_q),
    .mant_b (m2_q),
    .mant   (mant),
    .inc    (inc)
  );

  assign exp_sum = $signed({2'b00, e1_q} + {2'b00, e2_q}
                           + {{(EXP_W+1){1'b0}}, inc} - (EXP_W+2)'(BIAS));

  always_comb begin
    res_next = {sign_q, e1_q[0 +: 0+EXP_W] & 7'h00, {MANT_W{1'b0}}};
    ov_next  = 1'b0;
    un_next  = 1'b0;
    if (zero_q) begin
      res_next = {sign_q, {(W-1){1'b0}}};
    end else if (exp_sum >= $signed({2'b00, EXP_MAX})) begin
      res_next = {sign_q, EXP_MAX, {MANT_W{1'b0}}};
      ov_next  = 1'b1;
    end else if (exp_sum <= $signed((EXP_W+2)'(0))) begin
      res_next = {sign_q, {(W-1){1'b0}}};
      un_next  = 1'b1;
    end else begin
      res_next = {sign_q, exp_sum[EXP_W-1:0], mant};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      id_q        <= 1'b0;
      e1_q        <= '0;
      e2_q        <= '0;
      m1_q        <= '0;
      m2_q        <= '0;
      o_valid     <= 1'b0;
      o_resultado <= '0;
      o_id        <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
`ifdef ARBITRO_FP_RR_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (o_ready_a || o_ready_b) begin
            sign_q <= get_sign(sel_op1) ^ get_sign(sel_op2);
            zero_q <= (get_exp(sel_op1) == '0) || (get_exp(sel_op2) == '0);
            e1_q   <= get_exp(sel_op1);
            e2_q   <= get_exp(sel_op2);
            m1_q   <= get_mant(sel_op1);
            m2_q   <= get_mant(sel_op2);
            id_q   <= o_ready_b;
`ifdef ARBITRO_FP_RR_EN
            last_grant <= o_ready_b;
`endif
            state  <= CALC;
          end
        end
        CALC: begin
          o_resultado <= res_next;
          o_overflow  <= ov_next;
          o_underflow <= un_next;
          o_id        <= id_q;
          o_valid     <= 1'b1;
          state       <= RESULT;
        end
        RESULT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_multiplicador_fp.sv
// Directed self-checking bench for arbitro_multiplicador_fp; expected tie order
// follows ARBITRO_FP_RR_EN the same way the design does.
module tb_arbitro_multiplicador_fp;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid_a, i_valid_b;
  logic        o_ready_a, o_ready_b;
  logic [15:0] i_op1_a, i_op2_a, i_op1_b, i_op2_b;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_resultado;
  logic        o_id;
  logic        o_overflow, o_underflow;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  arbitro_multiplicador_fp dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid_a   (i_valid_a),
    .i_valid_b   (i_valid_b),
    .o_ready_a   (o_ready_a),
    .o_ready_b   (o_ready_b),
    .i_op1_a     (i_op1_a),
    .i_op2_a     (i_op2_a),
    .i_op1_b     (i_op1_b),
    .i_op2_b     (i_op2_b),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_resultado (o_resultado),
    .o_id        (o_id),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full transaction: request, latency, result, consumption
  task automatic applyStimulus(input string tag, input logic va, input logic vb,
                               input logic [15:0] a1, input logic [15:0] a2,
                               input logic [15:0] b1, input logic [15:0] b2,
                               input logic exp_id, input logic [15:0] exp_res,
                               input logic exp_ov, input logic exp_un);
    @(negedge i_clk);
    i_valid_a = va;
    i_valid_b = vb;
    i_op1_a = a1;
    i_op2_a = a2;
    i_op1_b = b1;
    i_op2_b = b2;
    #1;
    checkOutput({tag, "_ready_a"}, 32'(o_ready_a), 32'(!exp_id));
    checkOutput({tag, "_ready_b"}, 32'(o_ready_b), 32'(exp_id));
    @(negedge i_clk);
    i_valid_a = 1'b0;
    i_valid_b = 1'b0;
    i_op1_a = 16'hFFFF;
    i_op2_a = 16'hFFFF;
    i_op1_b = 16'hFFFF;
    i_op2_b = 16'hFFFF;
    #1;
    checkOutput({tag, "_valid_calc"}, 32'(o_valid), 32'd0);
    @(negedge i_clk);
    #1;
    checkOutput({tag, "_valid"}, 32'(o_valid), 32'd1);
    checkOutput({tag, "_res"}, 32'(o_resultado), 32'(exp_res));
    checkOutput({tag, "_id"}, 32'(o_id), 32'(exp_id));
    checkOutput({tag, "_flags"}, 32'({o_overflow, o_underflow}), 32'({exp_ov, exp_un}));
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    #1;
    checkOutput({tag, "_consumed"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    logic rr_second_id;
`ifdef ARBITRO_FP_RR_EN
    rr_second_id = 1'b1;
`else
    rr_second_id = 1'b0;
`endif
    i_rst = 1'b1;
    i_valid_a = 1'b1;
    i_valid_b = 1'b1;
    i_ready = 1'b0;
    i_op1_a = 16'h3F00;
    i_op2_a = 16'h3F00;
    i_op1_b = 16'h3F00;
    i_op2_b = 16'h3F00;
    #3;
    checkOutput("rst_ready", 32'({o_ready_a, o_ready_b}), 32'd0);
    checkOutput("rst_outs", 32'({o_valid, o_id, o_overflow, o_underflow, o_resultado}), 32'd0);
    @(negedge i_clk);
    i_valid_a = 1'b0;
    i_valid_b = 1'b0;
    i_rst = 1'b0;

    applyStimulus("a_one", 1, 0, 16'h3F00, 16'h3F00, 16'h0, 16'h0, 0, 16'h3F00, 0, 0);
    applyStimulus("b_inc", 0, 1, 16'h0, 16'h0, 16'h3F80, 16'h3F80, 1, 16'h4020, 0, 0);

    applyStimulus("tie1", 1, 1, 16'h3F00, 16'h3F00, 16'h3F80, 16'h3F80, 0, 16'h3F00, 0, 0);
    applyStimulus("tie2", 1, 1, 16'h3F00, 16'h3F00, 16'h3F80, 16'h3F80, rr_second_id,
                  rr_second_id ? 16'h4020 : 16'h3F00, 0, 0);
    applyStimulus("tie3", 1, 1, 16'h3F00, 16'h3F00, 16'h3F80, 16'h3F80, 0, 16'h3F00, 0, 0);

    applyStimulus("ovf", 1, 0, 16'h7000, 16'h7000, 16'h0, 16'h0, 0, 16'h7F00, 1, 0);
    applyStimulus("unf", 1, 0, 16'h1000, 16'h1000, 16'h0, 16'h0, 0, 16'h0000, 0, 1);
    applyStimulus("zero", 1, 0, 16'h8000, 16'h3F00, 16'h0, 16'h0, 0, 16'h8000, 0, 0);

    // Backpressure with a B request waiting behind the held result
    @(negedge i_clk);
    i_valid_a = 1'b1;
    i_op1_a = 16'h3F00;
    i_op2_a = 16'h3F00;
    @(negedge i_clk);
    i_valid_a = 1'b0;
    i_valid_b = 1'b1;
    i_op1_b = 16'h4000;
    i_op2_b = 16'h3F00;
    #1;
    checkOutput("bp_calc_ready_b", 32'(o_ready_b), 32'd0);
    @(negedge i_clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("bp_hold",
                  32'({o_valid, o_ready_a, o_ready_b, o_id, o_overflow, o_underflow, o_resultado}),
                  32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3F00}));
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    #1;
    checkOutput("bp_consumed", 32'(o_valid), 32'd0);
    checkOutput("bp_ready_b", 32'(o_ready_b), 32'd1);
    @(negedge i_clk);
    i_valid_b = 1'b0;
    @(negedge i_clk);
    #1;
    checkOutput("bp_b_valid", 32'(o_valid), 32'd1);
    checkOutput("bp_b_res", 32'(o_resultado), 32'h4000);
    checkOutput("bp_b_id", 32'(o_id), 32'd1);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;

    // Asynchronous reset while an operation is in CALC
    i_valid_a = 1'b1;
    i_op1_a = 16'h3F00;
    i_op2_a = 16'h3F00;
    @(negedge i_clk);
    i_valid_a = 1'b0;
    #1;
    i_rst = 1'b1;
    #1;
    checkOutput("mid_rst_outs", 32'({o_valid, o_id, o_overflow, o_underflow, o_resultado}), 32'd0);
    checkOutput("mid_rst_ready", 32'({o_ready_a, o_ready_b}), 32'd0);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    #1;
    checkOutput("mid_rst_discard", 32'(o_valid), 32'd0);

    applyStimulus("post_rst", 1, 0, 16'h3F80, 16'h3F00, 16'h0, 16'h0, 0, 16'h3F80, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arbitro_multiplicador_fp.md
# arbitro_multiplicador_fp

Two-requester arbiter and sequencer for one shared 16-bit floating-point multiplier. Two upstream requesters issue operand pairs over valid/ready handshakes. The block grants one requester at a time and runs the product through a single mantissa-multiplier instance, adding sign and exponent handling. It then holds the result, tagged with the requester ID, until downstream accepts it. It sits between the operand sources and the result consumer in the FP datapath.

## Interface
- `BIAS`, 63: exponent bias.
- `W`, 16: word width, fixed as `{sign[15], exp[14:8], mant[7:0]}`; the mantissa carries a hidden leading 1.
- `i_clk`  in  1  clock, rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_valid_a`, `i_valid_b`  in  1  request valid, per requester.
- `o_ready_a`, `o_ready_b`  out  1  request accepted this cycle.
- `i_op1_a`, `i_op2_a`, `i_op1_b`, `i_op2_b`  in  16  operands.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  downstream accepts the result.
- `o_resultado`  out  16  product.
- `o_id`  out  1  source of the result: 0 = A, 1 = B.
- `o_overflow`, `o_underflow`  out  1  exception flags, valid with `o_valid`.

## Operation
- FSM states:
  - `IDLE`: accepts a request. `CALC` is entered on a handshake.
  - `CALC`: computes and registers the result. `RESULT` is entered unconditionally.
  - `RESULT`: holds the output. `IDLE` is entered when `i_ready` is high.
- Handshake: `o_ready_x` is asserted only in `IDLE`, only for the granted requester, and only while its `i_valid_x` is high. `o_ready_a` and `o_ready_b` are never high together.
- Grant: with only one requester valid, that requester wins. With both valid, the requester not granted last wins (round-robin). The last-grant pointer resets to B, so A wins the first tie.
- Operands are captured on the handshake edge. Later changes on the request inputs do not affect the operation in flight.
- Sign: `s = s1 ^ s2`.
- Mantissa: taken from the sub-module, which outputs an 8-bit mantissa `m` and an increment flag `inc`.
- Exponent: computed as 9-bit signed, `e = e1 + e2 - BIAS + inc`.
- Zero: an operand with `exp == 0` is zero. The result is `{s, 15'h0}` and no flag is raised.
- Overflow: `e >= 127` gives `{s, 7'h7F, 8'h00}` with `o_overflow = 1`.
- Underflow: `e <= 0` gives `{s, 15'h0}` with `o_underflow = 1`.
- Output stability: `o_resultado`, `o_id` and both flags stay stable throughout `RESULT`.
- Reset mid-operation: the FSM returns to `IDLE` and any in-flight operation is discarded.

## Timing
- Reset values:
  - State `IDLE`.
  - `o_valid`, `o_resultado`, `o_id`, `o_overflow`, `o_underflow` all 0.
  - `o_ready_a`, `o_ready_b` are 0 while `i_rst` is high.
- Latency: a handshake at edge E0 gives `o_valid = 1` after E1.
- Result acceptance: the result is consumed at the first edge where `o_valid` and `i_ready` are both high. `o_valid` drops after that edge.
- The earliest next acceptance is in the cycle following consumption, so throughput is 1 operation per 3 cycles minimum.
- Backpressure: `i_ready` held low keeps the FSM in `RESULT` indefinitely. `o_ready_a` and `o_ready_b` stay 0 throughout.
- Registered outputs: `o_valid`, `o_resultado`, `o_id` and both flags. `o_ready_a` and `o_ready_b` are combinational from state, valids and the pointer.

## Configuration
- `ARBITRO_FP_RR_EN`
  - Defined: round-robin grant as described above.
  - Undefined: fixed priority, with A always winning a tie. The last-grant pointer is not implemented.

## Structure
- Shared package `fp_pkg` holds:
  - Field widths: `EXP_W = 7`, `MANT_W = 8`.
  - `BIAS`.
  - `EXP_MAX = 7'h7F`.
  - The state encoding: `IDLE`, `CALC`, `RESULT`.
  - Field-extraction helpers.
- One sub-module: the existing `multiplicador_mantiza` (8x8 hidden-one mantissa multiply), instantiated once. It is driven by the captured mantissas and its outputs are sampled in `CALC`.

## Test plan
- A: `0x3F00 * 0x3F00` (1.0 × 1.0) → `o_resultado = 0x3F00`, `o_id = 0`, no flags, `o_valid` 2 cycles after the handshake.
- B: `0x3F80 * 0x3F80` (1.5 × 1.5) → `0x4020`, with `inc = 1` applied to the exponent.
- A and B both valid for three consecutive operations → grant order A, B, A. Without `ARBITRO_FP_RR_EN` → A, A, A.
- `0x7000 * 0x7000` → `0x7F00` with `o_overflow = 1`. `0x1000 * 0x1000` → `0x0000` with `o_underflow = 1`. `0x8000 * 0x3F00` → `0x8000`, no flags.
- `i_ready` held low for 10 cycles during `RESULT` → `o_valid` and all outputs are stable, `o_ready_a` and `o_ready_b` stay 0, and a pending B request is accepted only after the result is consumed.
- `i_rst` pulsed asynchronously during `CALC` → all outputs go to 0 immediately. After release, a fresh A request produces a correct result.
